branch_predict_resolve_unit: RTL and testbench

- Predicts branch direction and target for the instruction in IF, using a direct-mapped table of 2-bit saturating counters and targets.
- Resolves each branch in ID from operands selected by the ID forwarding selects rd_srcA/rd_srcB.
- On mispredict, raises a redirect and an IF flush, and updates the table.
- Sits between the ID-stage forwarding unit (consumes its selects) and the PC/IF-ID pipeline control (drives redirect, flush and stall).

---
 rtl/cpu_ctrl_pkg.sv | 31 +++
 rtl/branch_history_table.sv | 64 ++++++
 rtl/branch_predict_resolve_unit.sv | 126 ++++++++++++
 tb/tb_branch_predict_resolve_unit.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// ============================================================================
// Module : cpu_ctrl_pkg
// Brief  : Shared control encodings (forwarding selects, branch types, counters)
// Rev    : 1.0
// ============================================================================
`default_nettype none

package cpu_ctrl_pkg;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_EX  = 2'b10;

  localparam logic BR_BEQ = 1'b0;
  localparam logic BR_BNE = 1'b1;

  typedef logic [1:0] ctr_t;

  localparam ctr_t CTR_INIT = 2'b01;

  function automatic ctr_t ctr_next(input ctr_t ctr, input logic taken);
    ctr_t r;
    r = ctr;
    if (taken && ctr != 2'b11) r = ctr + 2'b01;
    else if (!taken && ctr != 2'b00) r = ctr - 2'b01;
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/branch_history_table.sv
// ============================================================================
// Module : branch_history_table
// Brief  : Direct-mapped valid/2-bit counter/target table, comb read, sync update
// Rev    : 1.0
// ============================================================================
`default_nettype none

module branch_history_table
  import cpu_ctrl_pkg::*;
#(
  parameter int PC_W  = 8,
  parameter int IDX_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] rd_idx,
  output logic             rd_valid,
  output ctr_t             rd_ctr,
  output logic [PC_W-1:0]  rd_target,
  input  logic             upd_en,
  input  logic [IDX_W-1:0] upd_idx,
  input  logic             upd_taken,
  input  logic [PC_W-1:0]  upd_target
);

  localparam int DEPTH = 1 << IDX_W;

  logic [DEPTH-1:0]           valid_q, valid_d;
  logic [DEPTH-1:0][1:0]      ctr_q, ctr_d;
  logic [DEPTH-1:0][PC_W-1:0] target_q, target_d;

  always_comb begin
    valid_d  = valid_q;
    ctr_d    = ctr_q;
    target_d = target_q;
    if (upd_en) begin
      ctr_d[upd_idx] = ctr_next(ctr_q[upd_idx], upd_taken);
      // Not-taken outcomes only train the counter; the last taken target stays.
      if (upd_taken) begin
        valid_d[upd_idx]  = 1'b1;
        target_d[upd_idx] = upd_target;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q  <= '0;
      ctr_q    <= {DEPTH{CTR_INIT}};
      target_q <= '0;
    end else begin
      valid_q  <= valid_d;
      ctr_q    <= ctr_d;
      target_q <= target_d;
    end
  end

  assign rd_valid  = valid_q[rd_idx];
  assign rd_ctr    = ctr_q[rd_idx];
  assign rd_target = target_q[rd_idx];

endmodule

`default_nettype wire

// File: rtl/branch_predict_resolve_unit.sv
// ============================================================================
// Module : branch_predict_resolve_unit
// Brief  : IF-stage branch prediction with ID-stage resolution and redirect
// Rev    : 1.0
// ============================================================================
`default_nettype none

module branch_predict_resolve_unit
  import cpu_ctrl_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int PC_W   = 8,
  parameter int IDX_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [PC_W-1:0]   IF_pc,
  output logic              IF_pred_taken,
  output logic [PC_W-1:0]   IF_pred_target,
  input  logic              pipe_stall,
  input  logic [PC_W-1:0]   ID_pc,
  input  logic              ID_is_branch,
  input  logic              ID_branch_type,
  input  logic [PC_W-1:0]   ID_target,
  input  logic [DATA_W-1:0] ID_rs_data,
  input  logic [DATA_W-1:0] ID_rt_data,
  input  logic [DATA_W-1:0] EX_alu_result,
  input  logic [DATA_W-1:0] MEM_wb_data,
  input  logic              EX_MemRead,
  input  logic [1:0]        rd_srcA,
  input  logic [1:0]        rd_srcB,
  output logic              branch_stall,
  output logic              redirect_valid,
  output logic [PC_W-1:0]   redirect_pc,
  output logic              flush_IF,
  output logic [7:0]        mispredict_count
);

  logic              lk_valid;
  ctr_t              lk_ctr;
  logic [PC_W-1:0]   lk_target;
  logic              pred_taken_q, pred_taken_d;
  logic [PC_W-1:0]   pred_target_q, pred_target_d;
  logic [7:0]        mispredict_count_q, mispredict_count_d;
  logic [DATA_W-1:0] op_a, op_b;
  logic              resolve, taken, mispredict;
  logic              unused_pc_hi;

  assign unused_pc_hi = ^{IF_pc[PC_W-1:IDX_W], lk_ctr[0]};

  branch_history_table #(
    .PC_W  (PC_W),
    .IDX_W (IDX_W)
  ) u_bht (
    .clk        (clk),
    .rst_n      (rst_n),
    .rd_idx     (IF_pc[IDX_W-1:0]),
    .rd_valid   (lk_valid),
    .rd_ctr     (lk_ctr),
    .rd_target  (lk_target),
    .upd_en     (resolve),
    .upd_idx    (ID_pc[IDX_W-1:0]),
    .upd_taken  (taken),
    .upd_target (ID_target)
  );

  assign IF_pred_taken  = lk_valid & lk_ctr[1];
  assign IF_pred_target = lk_target;

  always_comb begin
    case (rd_srcA)
      FWD_MEM: op_a = MEM_wb_data;
      FWD_EX:  op_a = EX_alu_result;
      default: op_a = ID_rs_data;
    endcase
    case (rd_srcB)
      FWD_MEM: op_b = MEM_wb_data;
      FWD_EX:  op_b = EX_alu_result;
      default: op_b = ID_rt_data;
    endcase
  end

  // An EX-forwarded operand from a load is not ready yet; gating with rst_n
  // keeps control outputs quiet while reset is held.
  assign branch_stall = rst_n & ID_is_branch & EX_MemRead &
                        ((rd_srcA == FWD_EX) | (rd_srcB == FWD_EX));
  assign resolve      = rst_n & ID_is_branch & ~branch_stall & ~pipe_stall;
  assign taken        = (ID_branch_type == BR_BEQ) ? (op_a == op_b) : (op_a != op_b);
  assign mispredict   = resolve & ((taken != pred_taken_q) |
                        (taken & pred_taken_q & (pred_target_q != ID_target)));

  assign redirect_valid   = mispredict;
  assign flush_IF         = mispredict;
  assign redirect_pc      = taken ? ID_target : ID_pc + {{(PC_W-1){1'b0}}, 1'b1};
  assign mispredict_count = mispredict_count_q;

  always_comb begin
    pred_taken_d       = pred_taken_q;
    pred_target_d      = pred_target_q;
    mispredict_count_d = mispredict_count_q;
    if (flush_IF) begin
      pred_taken_d  = 1'b0;
      pred_target_d = '0;
    end else if (!(pipe_stall || branch_stall)) begin
      pred_taken_d  = IF_pred_taken;
      pred_target_d = IF_pred_target;
    end
    if (mispredict && mispredict_count_q != 8'hFF)
      mispredict_count_d = mispredict_count_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pred_taken_q       <= 1'b0;
      pred_target_q      <= '0;
      mispredict_count_q <= '0;
    end else begin
      pred_taken_q       <= pred_taken_d;
      pred_target_q      <= pred_target_d;
      mispredict_count_q <= mispredict_count_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_branch_predict_resolve_unit.sv
// ============================================================================
// Module : tb_branch_predict_resolve_unit
// Brief  : Scoreboard bench with directed and random stimulus against a model
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_branch_predict_resolve_unit;

  typedef struct {
    bit         rst;
    logic [7:0] if_pc, id_pc, tgt, rs, rt, ex, mem;
    bit         pstall, is_br, btype, memrd;
    logic [1:0] sa, sb;
  } stim_t;

  typedef struct {
    logic       pt, bs, rv, fl;
    logic [7:0] ptgt, rpc, cnt;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] IF_pc = '0, ID_pc = '0, ID_target = '0;
  logic [7:0] ID_rs_data = '0, ID_rt_data = '0, EX_alu_result = '0, MEM_wb_data = '0;
  logic       pipe_stall = 1'b0, ID_is_branch = 1'b0, ID_branch_type = 1'b0, EX_MemRead = 1'b0;
  logic [1:0] rd_srcA = '0, rd_srcB = '0;
  logic       IF_pred_taken, branch_stall, redirect_valid, flush_IF;
  logic [7:0] IF_pred_target, redirect_pc, mispredict_count;

  branch_predict_resolve_unit #(.DATA_W(8), .PC_W(8), .IDX_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .IF_pc(IF_pc), .IF_pred_taken(IF_pred_taken),
    .IF_pred_target(IF_pred_target), .pipe_stall(pipe_stall), .ID_pc(ID_pc),
    .ID_is_branch(ID_is_branch), .ID_branch_type(ID_branch_type), .ID_target(ID_target),
    .ID_rs_data(ID_rs_data), .ID_rt_data(ID_rt_data), .EX_alu_result(EX_alu_result),
    .MEM_wb_data(MEM_wb_data), .EX_MemRead(EX_MemRead), .rd_srcA(rd_srcA), .rd_srcB(rd_srcB),
    .branch_stall(branch_stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .flush_IF(flush_IF), .mispredict_count(mispredict_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  exp_t sb_q[$];

  // Reference model state: branch table, IF/ID prediction register, counter.
  bit         m_valid[16];
  int         m_ctr[16];
  logic [7:0] m_tgt[16];
  bit         m_pt;
  logic [7:0] m_ptgt;
  int         m_cnt;

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 0; m_ctr[i] = 1; m_tgt[i] = 8'h00;
    end
    m_pt = 0; m_ptgt = 8'h00; m_cnt = 0;
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cycle(input stim_t s);
    exp_t e;
    logic [7:0] a, b;
    bit bs, res, tk, mis, ipt;
    logic [7:0] itgt;
    int ix, dx;
    @(negedge clk);
    rst_n = ~s.rst; IF_pc = s.if_pc; ID_pc = s.id_pc; ID_target = s.tgt;
    ID_rs_data = s.rs; ID_rt_data = s.rt; EX_alu_result = s.ex; MEM_wb_data = s.mem;
    pipe_stall = s.pstall; ID_is_branch = s.is_br; ID_branch_type = s.btype;
    EX_MemRead = s.memrd; rd_srcA = s.sa; rd_srcB = s.sb;
    if (s.rst) model_reset();
    a = (s.sa == 2'd1) ? s.mem : (s.sa == 2'd2) ? s.ex : s.rs;
    b = (s.sb == 2'd1) ? s.mem : (s.sb == 2'd2) ? s.ex : s.rt;
    bs  = !s.rst && s.is_br && s.memrd && (s.sa == 2'd2 || s.sb == 2'd2);
    res = !s.rst && s.is_br && !bs && !s.pstall;
    tk  = s.btype ? (a != b) : (a == b);
    mis = res && ((tk != m_pt) || (tk && m_pt && m_ptgt != s.tgt));
    ix  = s.if_pc % 16;
    dx  = s.id_pc % 16;
    ipt  = m_valid[ix] && (m_ctr[ix] >= 2);
    itgt = m_tgt[ix];
    e.pt = ipt; e.ptgt = itgt; e.bs = bs; e.rv = mis; e.fl = mis;
    e.rpc = tk ? s.tgt : 8'((int'(s.id_pc) + 1) % 256);
    e.cnt = 8'(m_cnt);
    sb_q.push_back(e);
    if (!s.rst) begin
      if (mis) begin m_pt = 0; m_ptgt = 8'h00; end
      else if (!(s.pstall || bs)) begin m_pt = ipt; m_ptgt = itgt; end
      if (res) begin
        m_ctr[dx] = tk ? ((m_ctr[dx] < 3) ? m_ctr[dx] + 1 : 3)
                       : ((m_ctr[dx] > 0) ? m_ctr[dx] - 1 : 0);
        if (tk) begin m_valid[dx] = 1; m_tgt[dx] = s.tgt; end
      end
      if (mis && m_cnt < 255) m_cnt++;
    end
  endtask

  // Monitor: outputs are combinational, so each cycle presents one response.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check("IF_pred_taken", {7'd0, IF_pred_taken}, {7'd0, e.pt});
        check("IF_pred_target", IF_pred_target, e.ptgt);
        check("branch_stall", {7'd0, branch_stall}, {7'd0, e.bs});
        check("redirect_valid", {7'd0, redirect_valid}, {7'd0, e.rv});
        check("flush_IF", {7'd0, flush_IF}, {7'd0, e.fl});
        check("redirect_pc", redirect_pc, e.rpc);
        check("mispredict_count", mispredict_count, e.cnt);
      end
    end
  end

  function automatic stim_t br(input logic [7:0] pc, input logic [7:0] tgt, input bit bne,
                               input logic [7:0] rs, input logic [7:0] rt);
    stim_t s;
    s = '{default: '0};
    s.is_br = 1; s.id_pc = pc; s.if_pc = pc; s.tgt = tgt; s.btype = bne; s.rs = rs; s.rt = rt;
    return s;
  endfunction

  initial begin
    stim_t s;
    logic [7:0] pcs[4];
    pcs[0] = 8'h10; pcs[1] = 8'h20; pcs[2] = 8'hFF; pcs[3] = 8'h05;
    model_reset();
    s = '{default: '0}; s.rst = 1;
    cycle(s); cycle(s);
    // Cold BEQ taken, then train to saturation, then one not-taken.
    for (int i = 0; i < 4; i++) cycle(br(8'h10, 8'h20, 0, 8'h05, 8'h05));
    cycle(br(8'h10, 8'h20, 0, 8'h05, 8'h06));
    // BNE using EX-forwarded operand, then the same with a load in EX.
    s = br(8'h10, 8'h20, 1, 8'h00, 8'h07); s.sa = 2'b10; s.ex = 8'h07;
    cycle(s);
    s.memrd = 1; cycle(s); cycle(s);
    // Predicted taken to 0x30 but resolves taken to 0x40.
    cycle(br(8'h05, 8'h30, 0, 8'h01, 8'h01));
    s = '{default: '0}; s.if_pc = 8'h05; cycle(s);
    cycle(br(8'h05, 8'h40, 0, 8'h01, 8'h01));
    // Wrap of ID_pc + 1 on a not-taken mispredict.
    cycle(br(8'hFF, 8'h33, 0, 8'h02, 8'h02));
    s = '{default: '0}; s.if_pc = 8'hFF; cycle(s);
    cycle(br(8'hFF, 8'h33, 0, 8'h02, 8'h03));
    // pipe_stall suppresses a would-be mispredict.
    s = br(8'h20, 8'h44, 0, 8'h09, 8'h09); s.pstall = 1; cycle(s);
    // Back-to-back taken branches keep mispredicting: counter saturation.
    for (int i = 0; i < 300; i++) begin
      s = br(8'h30, 8'h50, 0, 8'h01, 8'h01); s.if_pc = 8'h00; cycle(s);
    end
    for (int i = 0; i < 1500; i++) begin
      s = '{default: '0};
      s.rst    = (i == 700);
      s.is_br  = ($urandom_range(0, 3) != 0);
      s.btype  = $urandom_range(0, 1) != 0;
      s.id_pc  = ($urandom_range(0, 3) == 0) ? 8'($urandom) : pcs[$urandom_range(0, 3)];
      s.if_pc  = ($urandom_range(0, 1) == 0) ? s.id_pc : pcs[$urandom_range(0, 3)];
      s.tgt    = 8'h30 + 8'($urandom_range(0, 2)) * 8'h10;
      s.rs = 8'($urandom_range(0, 2)); s.rt = 8'($urandom_range(0, 2));
      s.ex = 8'($urandom_range(0, 2)); s.mem = 8'($urandom_range(0, 2));
      s.sa = 2'($urandom_range(0, 3)); s.sb = 2'($urandom_range(0, 3));
      s.memrd  = ($urandom_range(0, 3) == 0);
      s.pstall = ($urandom_range(0, 7) == 0);
      cycle(s);
    end
    s = '{default: '0}; cycle(s);
    repeat (3) @(negedge clk);
    check("scoreboard_drained", 8'(sb_q.size()), 8'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
